// File: rtl/apb_requester.sv
// APB3 requester: one command per SETUP/ACCESS pair, response pulses the cycle after PREADY (3 cycles min).
// No response backpressure; cmd_ready is high only while idle, and stalled transfers abort after TIMEOUT waits.
module apb_requester #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = 8'd0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        // A ready slave on the limit cycle still completes normally.
        if (PREADY || (wait_cnt_q == WAIT_LIMIT)) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
          rsp_err_d     = PREADY ? PSLVERR : 1'b1;
          rsp_timeout_d = !PREADY;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = IDLE;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      wait_cnt_q    <= 8'd0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
